// File: rtl/button_evt_pkg.sv
// Shared state encoding and default timing for the button event decoder.
package button_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HOLD    = 2'd2
  } btn_state_t;

  // Defaults assume a 100 MHz clock: long press 0.5 s, repeat every 0.1 s.
  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;
  localparam int unsigned CNT_W_DEF         = 26;
  localparam int unsigned PCNT_W            = 8;

endpackage

// File: rtl/button_edge_detect.sv
// Rise/fall detector on the debounced level; pb_prev resets high so a button
// held through reset yields no event until it is released and pressed again.
module button_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pb,
  output logic o_rise,
  output logic o_fall
);

  logic r_pb_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pb_prev <= 1'b1;
    else       r_pb_prev <= i_pb;
  end

  assign o_rise = i_pb & ~r_pb_prev;
  assign o_fall = ~i_pb & r_pb_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into registered single-cycle event strobes:
// press, release, click, long press and auto-repeat while held.
module button_event_decoder
  import button_evt_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pb_in,
  output logic              held,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              click_pulse,
  output logic              long_pulse,
  output logic              repeat_pulse,
  output logic [PCNT_W-1:0] press_count
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 || CNT_W < 1 ||
      ((64'(MAX_CYCLES) - 64'd1) >> CNT_W) != 64'd0) begin : g_param_check
    $error("button_event_decoder: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [PCNT_W-1:0] r_press_count, w_press_count_nxt;
  logic r_held, w_held_nxt;
  logic r_press, w_press_nxt;
  logic r_release, w_release_nxt;
  logic r_click, w_click_nxt;
  logic r_long, w_long_nxt;
  logic r_repeat, w_repeat_nxt;
  logic w_rise, w_fall, w_long_hit, w_rep_hit;

  button_edge_detect u_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pb   (pb_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_long_hit = (r_cnt == LONG_LAST);
  assign w_rep_hit  = (r_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A release on the same edge as a threshold match takes priority.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_rise) w_state_nxt = ST_PRESSED;
      ST_PRESSED: begin
        if (w_fall)          w_state_nxt = ST_IDLE;
        else if (w_long_hit) w_state_nxt = ST_HOLD;
      end
      ST_HOLD:    if (w_fall) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt         = r_cnt;
    w_press_count_nxt = r_press_count;
    w_held_nxt        = r_held;
    w_press_nxt       = 1'b0;
    w_release_nxt     = 1'b0;
    w_click_nxt       = 1'b0;
    w_long_nxt        = 1'b0;
    w_repeat_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_cnt_nxt         = '0;
          w_press_nxt       = 1'b1;
          w_press_count_nxt = r_press_count + PCNT_W'(1);
          w_held_nxt        = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (w_fall) begin
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
          w_click_nxt   = 1'b1;
          w_held_nxt    = 1'b0;
        end else if (w_long_hit) begin
          w_cnt_nxt  = '0;
          w_long_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_fall) begin
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
          w_held_nxt    = 1'b0;
        end else if (w_rep_hit) begin
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt  = '0;
        w_held_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_press_count <= '0;
      r_held        <= 1'b0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_click       <= 1'b0;
      r_long        <= 1'b0;
      r_repeat      <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_press_count <= w_press_count_nxt;
      r_held        <= w_held_nxt;
      r_press       <= w_press_nxt;
      r_release     <= w_release_nxt;
      r_click       <= w_click_nxt;
      r_long        <= w_long_nxt;
      r_repeat      <= w_repeat_nxt;
    end
  end

  assign held          = r_held;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign click_pulse   = r_click;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;
  assign press_count   = r_press_count;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios plus random button traffic,
// checked every cycle against a timing model based on edges-since-press.
module tb_button_event_decoder;

  localparam int LONG = 8;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_in = 1'b0;
  logic       held, press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse;
  logic [7:0] press_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic m_prev = 1'b1;
  logic m_pressed = 1'b0;
  int   m_t = 0;
  int   m_count = 0;
  logic e_press, e_release, e_click, e_long, e_repeat;

  int long_seen, rep_seen, click_seen;

  button_event_decoder #(
    .LONG_CYCLES   (LONG),
    .REPEAT_CYCLES (REP),
    .CNT_W         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pb_in         (pb_in),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .click_pulse   (click_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .press_count   (press_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // m_t counts edges since the press edge; events follow from plain arithmetic on it.
  task automatic model_edge(input logic pb, input logic r);
    logic rise, fall;
    e_press = 0; e_release = 0; e_click = 0; e_long = 0; e_repeat = 0;
    if (r) begin
      m_prev = 1'b1; m_pressed = 1'b0; m_t = 0; m_count = 0;
    end else begin
      rise = pb && !m_prev;
      fall = !pb && m_prev;
      if (!m_pressed) begin
        if (rise) begin
          m_pressed = 1'b1; m_t = 0; e_press = 1'b1;
          m_count = (m_count + 1) % 256;
        end
      end else begin
        m_t++;
        if (fall) begin
          m_pressed = 1'b0; e_release = 1'b1;
          e_click = (m_t <= LONG);
        end else if (m_t == LONG) begin
          e_long = 1'b1;
        end else if (m_t > LONG && (m_t - LONG) % REP == 0) begin
          e_repeat = 1'b1;
        end
      end
      m_prev = pb;
    end
  endtask

  task automatic step(input logic pb, input logic r);
    pb_in = pb;
    rst   = r;
    @(posedge clk);
    model_edge(pb, r);
    #1;
    chk("held",    8'(held),          8'(m_pressed));
    chk("press",   8'(press_pulse),   8'(e_press));
    chk("release", 8'(release_pulse), 8'(e_release));
    chk("click",   8'(click_pulse),   8'(e_click));
    chk("long",    8'(long_pulse),    8'(e_long));
    chk("repeat",  8'(repeat_pulse),  8'(e_repeat));
    chk("count",   press_count,       8'(m_count));
    long_seen  += int'(long_pulse);
    rep_seen   += int'(repeat_pulse);
    click_seen += int'(click_pulse);
  endtask

  task automatic clear_seen();
    long_seen = 0; rep_seen = 0; click_seen = 0;
  endtask

  initial begin
    clear_seen();
    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rst_count", press_count, 8'd0);
    chk("rst_held", 8'(held), 8'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    // 1: short click, held for 4 cycles
    clear_seen();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t1_click", 8'(click_pulse), 8'd1);
    chk("t1_count", press_count, 8'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("t1_no_long", 8'(long_seen), 8'd0);

    // 2: long hold for 20 cycles -> long at +8, repeats at +11,+14,+17
    clear_seen();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t2_release", 8'(release_pulse), 8'd1);
    chk("t2_long_n", 8'(long_seen), 8'd1);
    chk("t2_rep_n", 8'(rep_seen), 8'd3);
    chk("t2_click_n", 8'(click_seen), 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // 3: fall exactly on the long threshold edge
    clear_seen();
    for (int i = 0; i < LONG; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("t3_click", 8'(click_pulse), 8'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    chk("t3_no_long", 8'(long_seen), 8'd0);

    // 4: button held through reset
    step(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    chk("t4_quiet_held", 8'(held), 8'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("t4_press", 8'(press_pulse), 8'd1);
    chk("t4_count", press_count, 8'd1);
    step(1'b1, 1'b0);
    chk("t4_press_once", 8'(press_pulse), 8'd0);

    // 5: reset while in HOLD
    for (int i = 0; i < LONG + 2; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t5_held", 8'(held), 8'd0);
    chk("t5_count", press_count, 8'd0);
    for (int i = 0; i < 2 * REP + 2; i++) step(1'b1, 1'b0);
    chk("t5_no_press", press_count, 8'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0);

    // 6: press_count wrap over 257 clicks
    for (int n = 1; n <= 257; n++) begin
      step(1'b1, 1'b0);
      if (n == 256) chk("t6_wrap", press_count, 8'd0);
      if (n == 257) chk("t6_after_wrap", press_count, 8'd1);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end

    // Random button traffic with occasional resets
    for (int seg = 0; seg < 150; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 25));
      for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
